// File: rtl/parity_prefix_stream_pkg.sv
// Shared defaults and elaboration helpers for the parity prefix stream block.
package parity_prefix_stream_pkg;

  localparam int DEF_WIDTH = 32'sd8;
  localparam int DEF_IDX_W = 32'sd8;

  // Number of doubling stages a log-depth prefix network needs to cover w bits.
  function automatic int unsigned prefix_levels(input int unsigned w);
    int unsigned lv;
    lv = 32'd0;
    while ((32'd1 << lv) < w) begin
      lv = lv + 32'd1;
    end
    return lv;
  endfunction

endpackage

// File: rtl/parity_prefix_stream_prefix.sv
// ParityPrefix: combinational XOR prefix scan, prefix[k] = data[0] ^ ... ^ data[k],
// built as a Kogge-Stone style network of log2(p_WIDTH) doubling stages.
module ParityPrefix
  import parity_prefix_stream_pkg::*;
#(
  parameter int p_WIDTH = DEF_WIDTH
) (
  input  logic [p_WIDTH-1:0] data,
  output logic [p_WIDTH-1:0] prefix
);

  localparam int unsigned LEVELS = prefix_levels(p_WIDTH);

  // Stage s folds in the partial result from 2^s positions lower.
  always_comb begin
    prefix = data;
    for (int unsigned s = 0; s < LEVELS; s++) begin
      prefix = prefix ^ (prefix << (32'd1 << s));
    end
  end

endmodule

// File: rtl/parity_prefix_stream.sv
// Streaming running-parity transform with a per-frame carry and a 2-entry skid
// buffer so that o_in_ready comes straight from a register.
module parity_prefix_stream
  import parity_prefix_stream_pkg::*;
#(
  parameter int p_WIDTH = DEF_WIDTH,
  parameter int p_IDX_W = DEF_IDX_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [p_WIDTH-1:0] iwv_in_data,
  input  logic               i_in_last,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [p_WIDTH-1:0] owv_out_data,
  output logic               o_out_last,
  output logic [p_IDX_W-1:0] owv_out_idx
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state;
  logic               carry;
  logic [p_IDX_W-1:0] idx;
  logic [p_WIDTH-1:0] skid_data;
  logic               skid_last;
  logic [p_IDX_W-1:0] skid_idx;
  logic [p_WIDTH-1:0] prefix;
  logic [p_WIDTH-1:0] word_data;
  logic               accept;
  logic               consume;

  ParityPrefix #(
    .p_WIDTH(p_WIDTH)
  ) u_prefix (
    .data  (iwv_in_data),
    .prefix(prefix)
  );

  assign accept    = i_in_valid & o_in_ready;
  assign consume   = o_out_valid & i_out_ready;
  // The top bit of the carried word is the parity of everything seen so far.
  assign word_data = prefix ^ {p_WIDTH{carry}};

  // Frame carry/index tracking and the skid FSM with its registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= EMPTY;
      carry        <= 1'b0;
      idx          <= '0;
      o_in_ready   <= 1'b1;
      o_out_valid  <= 1'b0;
      owv_out_data <= '0;
      o_out_last   <= 1'b0;
      owv_out_idx  <= '0;
      skid_data    <= '0;
      skid_last    <= 1'b0;
      skid_idx     <= '0;
    end else begin
      if (accept) begin
        if (i_in_last) begin
          carry <= 1'b0;
          idx   <= '0;
        end else begin
          carry <= word_data[p_WIDTH-1];
          idx   <= idx + p_IDX_W'(1);
        end
      end

      case (state)
        EMPTY: begin
          if (accept) begin
            owv_out_data <= word_data;
            o_out_last   <= i_in_last;
            owv_out_idx  <= idx;
            state        <= ONE;
            o_in_ready   <= 1'b1;
            o_out_valid  <= 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            owv_out_data <= word_data;
            o_out_last   <= i_in_last;
            owv_out_idx  <= idx;
          end else if (accept) begin
            skid_data  <= word_data;
            skid_last  <= i_in_last;
            skid_idx   <= idx;
            state      <= TWO;
            o_in_ready <= 1'b0;
          end else if (consume) begin
            state       <= EMPTY;
            o_out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (consume) begin
            owv_out_data <= skid_data;
            o_out_last   <= skid_last;
            owv_out_idx  <= skid_idx;
            state        <= ONE;
            o_in_ready   <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          o_in_ready  <= 1'b1;
          o_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_prefix_stream.sv
// Scoreboard bench: a bit-serial reference model queues expected words on acceptance,
// an independent monitor compares them against the presented outputs.
module tb_parity_prefix_stream;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [7:0] out_idx;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [7:0] i;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   accepted = 0;
  int   rnd_start;
  bit   m_c;
  int   m_idx;
  bit   m_run;
  logic [7:0] m_e;

  parity_prefix_stream #(.p_WIDTH(8), .p_IDX_W(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .iwv_in_data (in_data),
    .i_in_last   (in_last),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .owv_out_data(out_data),
    .o_out_last  (out_last),
    .owv_out_idx (out_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: walk the bits serially, carrying parity across the frame.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_c   = 1'b0;
      m_idx = 0;
    end else if (in_valid && in_ready) begin
      m_run = m_c;
      for (int k = 0; k < 8; k++) begin
        m_run  = m_run ^ in_data[k];
        m_e[k] = m_run;
      end
      q.push_back('{m_e, in_last, 8'(m_idx)});
      accepted++;
      if (in_last) begin
        m_c   = 1'b0;
        m_idx = 0;
      end else begin
        m_c   = m_run;
        m_idx = (m_idx + 1) % 256;
      end
    end
  end

  // Monitor: whatever is presented must match the oldest outstanding word.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL sb_unexpected got data=%h last=%0d idx=%0d required no output",
                 out_data, out_last, out_idx);
      end else begin
        mon_e = q[0];
        if (out_data === mon_e.d && out_last === mon_e.l && out_idx === mon_e.i) begin
          passes++;
        end else begin
          $display("FAIL sb_word got data=%h last=%0d idx=%0d required data=%h last=%0d idx=%0d",
                   out_data, out_last, out_idx, mon_e.d, mon_e.l, mon_e.i);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got %0h required %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;

    // Two-word frame, then a single-word frame proving the carry cleared.
    out_ready = 1'b1;
    drive(1'b1, 8'h01, 1'b0);
    step();
    chk("f1_w0_valid", out_valid, 1);
    chk("f1_w0_data", out_data, 32'hFF);
    chk("f1_w0_idx", out_idx, 0);
    drive(1'b1, 8'h03, 1'b1);
    step();
    chk("f1_w1_data", out_data, 32'hFE);
    chk("f1_w1_idx", out_idx, 1);
    chk("f1_w1_last", out_last, 1);
    drive(1'b1, 8'h80, 1'b1);
    step();
    chk("f2_data", out_data, 32'h80);
    chk("f2_idx", out_idx, 0);
    drive(1'b0, 8'h00, 1'b0);
    step();
    chk("idle_valid", out_valid, 0);

    // Alternating pattern with even parity keeps the carry at zero.
    drive(1'b1, 8'hFF, 1'b0);
    step();
    chk("alt_w0_data", out_data, 32'h55);
    drive(1'b1, 8'h00, 1'b0);
    step();
    chk("alt_w1_data", out_data, 32'h00);
    chk("alt_w1_idx", out_idx, 1);
    drive(1'b1, 8'h00, 1'b1);
    step();
    chk("alt_w2_data", out_data, 32'h00);
    chk("alt_w2_idx", out_idx, 2);
    drive(1'b0, 8'h00, 1'b0);
    step();

    // Backpressure: A and B fill the skid, C waits, then all drain without a gap.
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 1'b0);
    step();
    chk("bp_ready_one", in_ready, 1);
    drive(1'b1, 8'h22, 1'b0);
    step();
    chk("bp_ready_two", in_ready, 0);
    drive(1'b1, 8'h33, 1'b1);
    step();
    chk("bp_ready_hold", in_ready, 0);
    chk("bp_valid_hold", out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("bp_ready_reopen", in_ready, 1);
    chk("bp_stream_b", out_valid, 1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("bp_stream_c", out_valid, 1);
    step();
    chk("bp_drained", out_valid, 0);

    // Reset mid-frame while both entries are occupied.
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 1'b0);
    step();
    drive(1'b1, 8'h02, 1'b0);
    step();
    chk("mid_full", in_ready, 0);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_idx", out_idx, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 8'h01, 1'b1);
    step();
    chk("post_rst_data", out_data, 32'hFF);
    chk("post_rst_idx", out_idx, 0);
    chk("post_rst_last", out_last, 1);

    // Long frame to exercise index wrap-around.
    for (int i = 0; i < 258; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      step();
      if (i == 255) chk("wrap_idx_255", out_idx, 255);
      if (i == 256) chk("wrap_idx_0", out_idx, 0);
    end
    drive(1'b1, 8'h5A, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    step();

    // Randomized valid/ready traffic.
    rnd_start = accepted;
    for (int cyc = 0; cyc < 60000 && (accepted - rnd_start) < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("random_words_accepted", 32'((accepted - rnd_start) >= 10000), 1);

    drive(1'b0, 8'h00, 1'b0);
    out_ready = 1'b1;
    repeat (4) step();
    chk("final_queue_empty", q.size(), 0);
    chk("final_out_valid", out_valid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/parity_prefix_stream.md
PARITY_PREFIX_STREAM -- requirements
Module: parity_prefix_stream

Interface
REQ-001 Parameter p_WIDTH, default 8: data word width in bits; SHALL be greater than zero.
REQ-002 Parameter p_IDX_W, default 8: width of the in-frame word index; SHALL be greater than zero.
REQ-003 i_clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-004 i_rst  input  1  reset; synchronous, active-high.
REQ-005 i_in_valid  input  1  upstream word valid.
REQ-006 o_in_ready  output  1  block can accept a word; driven directly from a register.
REQ-007 iwv_in_data  input  p_WIDTH  input word; bit 0 is earliest in the serial order.
REQ-008 i_in_last  input  1  word is the final word of its frame.
REQ-009 o_out_valid  output  1  output word valid.
REQ-010 i_out_ready  input  1  downstream accepts the output word.
REQ-011 owv_out_data  output  p_WIDTH  running prefix parity of the frame, one bit per input bit.
REQ-012 o_out_last  output  1  i_in_last of the corresponding input word.
REQ-013 owv_out_idx  output  p_IDX_W  zero-based index of the word within its frame.

Function
REQ-014 An input word SHALL be accepted in a cycle when i_in_valid and o_in_ready are both 1; an output word SHALL be consumed when o_out_valid and i_out_ready are both 1.
REQ-015 Carry register c: parity of all accepted words of the current frame. Each accepted word SHALL produce owv_out_data[k] = c XOR iwv_in_data[0] XOR ... XOR iwv_in_data[k].
REQ-016 On acceptance: if i_in_last=1, c<=0 and idx<=0; otherwise c<=c XOR (XOR-reduce of iwv_in_data), and idx<=idx+1 wrapping modulo 2^p_IDX_W. c and idx SHALL NOT change without an acceptance.
REQ-017 Latency SHALL be exactly 1 cycle: a word accepted in cycle n is visible on the outputs in cycle n+1 when the output register is empty or being drained.
REQ-018 Sustained throughput SHALL be 1 word/cycle while i_out_ready=1.
REQ-019 Buffering: a 2-entry skid (main and skid registers), with states EMPTY, ONE, TWO.
REQ-020 Transitions: EMPTY+accept->ONE; ONE+accept+no consume->TWO; ONE+consume+no accept->EMPTY; ONE+accept+consume->ONE; TWO+consume->ONE; all other combinations hold the current state.
REQ-021 o_in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO. o_out_valid SHALL be 1 in ONE and TWO. Outputs always present the main entry; in TWO, a consume moves the skid entry to main.
REQ-022 Output word order SHALL equal acceptance order; no word SHALL be dropped or duplicated.
REQ-023 While o_out_valid=1 and i_out_ready=0, owv_out_data, o_out_last and owv_out_idx SHALL hold stable.
REQ-024 Inputs presented while o_in_ready=0 SHALL be ignored and SHALL NOT affect c or idx.

Reset
REQ-025 When i_rst=1 at a clock edge: state<=EMPTY, c<=0, idx<=0, o_in_ready<=1, o_out_valid<=0, owv_out_data<=0, o_out_last<=0, owv_out_idx<=0; skid contents cleared.
REQ-026 Reset mid-frame SHALL discard all buffered words. The first word accepted after reset SHALL start a new frame.
REQ-027 i_rst SHALL take priority over any simultaneous handshake; no acceptance or consume occurs in the reset cycle.

Structure
REQ-028 No shared package is required; the state encoding (EMPTY/ONE/TWO) SHALL be local constants of the module.
REQ-029 The per-word prefix SHALL be computed by one instance of the library ParityPrefix module (p_WIDTH=p_WIDTH, depth O(log N)). The carry XOR is applied to its output.
REQ-030 The skid logic SHALL remain inline; no other sub-modules.

Verification (p_WIDTH=8, p_IDX_W=8)
REQ-031 Frame 0x01(last=0), 0x03(last=1), with i_out_ready=1 -> outputs 0xFF idx0 last0, then 0xFE idx1 last1, on consecutive cycles, each 1 cycle after acceptance.
REQ-032 Next frame 0x80(last=1) after REQ-031 -> 0x80 idx0, confirming carry cleared.
REQ-033 i_out_ready=0, valid words A,B,C driven back-to-back -> A and B accepted; o_in_ready=0 from cycle 2; C held. Raise i_out_ready -> A, B, C out in order, no gap once streaming.
REQ-034 Frame 0xFF, 0x00, 0x00(last) -> 0xAA?-style check: outputs 0x55, 0x00, 0x00 (bit pattern 1,0,1,0...; parity of 0xFF is 0, so carry stays 0).
REQ-035 i_rst asserted mid-frame after 0x01(last=0) accepted and held in TWO -> all outputs zero, o_in_ready=1; then 0x01(last=1) -> 0xFF idx0.
REQ-036 Random valid/ready toggling over 10k words vs a bit-serial reference model -> exact match of data, last and idx.
